// File: rtl/debounce_scheduler.sv
// ---------------------------------------------------------------------------
// debounce_scheduler
//   Debounces N_CH switch inputs using a single shared delay counter. A
//   channel whose synchronized input differs from its debounced level
//   requests the timer; a round-robin arbiter hands it to one channel at a
//   time. When that channel's window expires, the input is sampled again. If
//   it still differs, the debounced level follows it and, on a rising
//   transition, a one-cycle press pulse is emitted.
//
// Optional feature (macro RELEASE_PULSE_EN):
//   When defined, adds output release_shot, which gives a one-cycle pulse on
//   each confirmed 1->0 transition.
//
// Ports
//   clk           in   1     system clock, rising edge
//   rst           in   1     asynchronous reset, active low
//   sw            in   N_CH  raw switch inputs (asynchronous to clk)
//   one_shot      out  N_CH  one-cycle pulse per confirmed 0->1 transition
//   level         out  N_CH  debounced switch level
//   busy          out  1     shared timer currently owned by a channel
//   release_shot  out  N_CH  (RELEASE_PULSE_EN only) pulse per confirmed 1->0
// ---------------------------------------------------------------------------
module debounce_scheduler #(
   parameter int N_CH      = 4,
   parameter int DELAY_CYC = 50000,
   parameter int CNT_W     = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] sw,
   output logic [N_CH-1:0] one_shot,
   output logic [N_CH-1:0] level,
   output logic            busy
`ifdef RELEASE_PULSE_EN
   ,
   output logic [N_CH-1:0] release_shot
`endif
);

   localparam int OW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DELAY_CYC - 1);
   localparam logic [OW-1:0]    OWNER_LAST = OW'(N_CH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t          state, state_nxt;
   logic [N_CH-1:0] sync_q1, sync_q2;
   logic [N_CH-1:0] req;
   logic [CNT_W-1:0] cnt;
   logic [OW-1:0]   owner;
   logic [OW-1:0]   rr_ptr;
   logic [OW-1:0]   pick;

   // Two-flop synchronizer per input bit.
   // NOTE: sequential state uses non-blocking assignments so that every flop
   // samples the pre-edge value of the flops that feed it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= sw;
         sync_q2 <= sync_q1;
      end
   end

   assign req  = sync_q2 ^ level;
   assign busy = (state != S_IDLE);

   // Round-robin pick: the first requester found when scanning from rr_ptr.
   // NOTE: every variable driven here gets a default first, so no path
   // through the block leaves it unassigned (no latch).
   always_comb begin
      logic found;
      int   idx;
      pick  = rr_ptr;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N_CH; k++) begin
         idx = (int'(rr_ptr) + k) % N_CH;
         if (!found && req[OW'(idx)]) begin
            pick  = OW'(idx);
            found = 1'b1;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (|req) state_nxt = S_RUN;
         S_RUN:   if (cnt == CNT_LAST) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Timer, ownership, debounced levels and pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         owner    <= '0;
         rr_ptr   <= '0;
         level    <= '0;
         one_shot <= '0;
`ifdef RELEASE_PULSE_EN
         release_shot <= '0;
`endif
      end else begin
         one_shot <= '0;
`ifdef RELEASE_PULSE_EN
         release_shot <= '0;
`endif
         unique case (state)
            S_IDLE: begin
               if (|req) begin
                  owner <= pick;
                  cnt   <= '0;
               end
            end
            S_RUN: begin
               // Input changes on the owner during the window are ignored;
               // only the sample taken in S_DONE matters.
               if (cnt != CNT_LAST) cnt <= cnt + CNT_W'(1);
            end
            S_DONE: begin
               if (sync_q2[owner] != level[owner]) begin
                  level[owner] <= sync_q2[owner];
                  if (sync_q2[owner]) one_shot[owner] <= 1'b1;
`ifdef RELEASE_PULSE_EN
                  else                release_shot[owner] <= 1'b1;
`endif
               end
               // The pointer advances past the owner even on a glitch, so a
               // chattering switch cannot monopolise the timer.
               rr_ptr <= (owner == OWNER_LAST) ? '0 : owner + OW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_debounce_scheduler.sv
// ---------------------------------------------------------------------------
// tb_debounce_scheduler
//   Directed bench for debounce_scheduler (N_CH=4, DELAY_CYC=8, CNT_W=4).
//   The stimulus pushes each expected pulse (value and cycle) into a queue.
//   A monitor pops an entry and compares it whenever a pulse output is
//   nonzero. Level, busy and reset behaviour are checked directly.
// ---------------------------------------------------------------------------
module tb_debounce_scheduler;

   localparam int N_CH = 4;
   localparam int DLY  = 8;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [N_CH-1:0] sw  = '0;
   logic [N_CH-1:0] one_shot;
   logic [N_CH-1:0] level;
   logic            busy;
`ifdef RELEASE_PULSE_EN
   logic [N_CH-1:0] release_shot;
`endif

   debounce_scheduler #(.N_CH(N_CH), .DELAY_CYC(DLY), .CNT_W(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .sw       (sw),
      .one_shot (one_shot),
      .level    (level),
      .busy     (busy)
`ifdef RELEASE_PULSE_EN
      ,
      .release_shot (release_shot)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit              rel;
      logic [N_CH-1:0] val;
      int              cyc;
   } exp_t;

   exp_t q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_pulse(input bit rel, input logic [N_CH-1:0] val, input int at);
      exp_t e;
      e.rel = rel;
      e.val = val;
      e.cyc = at;
      q.push_back(e);
   endtask

   task automatic compare(input bit rel, input logic [N_CH-1:0] val);
      exp_t e;
      n_cmp++;
      if (q.size() == 0) begin
         n_fail++;
         $display("FAIL unexpected_pulse: rel=%0d got %b at cycle %0d, none expected", rel, val, cyc);
      end else begin
         e = q.pop_front();
         if (e.rel != rel || e.val !== val || e.cyc != cyc) begin
            n_fail++;
            $display("FAIL pulse: got rel=%0d %b at cycle %0d, expected rel=%0d %b at cycle %0d",
                     rel, val, cyc, e.rel, e.val, e.cyc);
         end
      end
   endtask

   // Monitor: any nonzero pulse output must match the head of the queue.
   always @(negedge clk) begin
      if (one_shot !== '0) compare(1'b0, one_shot);
`ifdef RELEASE_PULSE_EN
      if (release_shot !== '0) compare(1'b1, release_shot);
`endif
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Observe busy for n cycles; optionally change sw after cycle drop_at.
   task automatic watch_busy(input int n, input int drop_at, input logic [N_CH-1:0] drop_val,
                             output int hi, output int first);
      hi    = 0;
      first = -1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (busy) begin
            hi++;
            if (first < 0) first = cyc;
         end
         if (i == drop_at) sw = drop_val;
      end
   endtask

   task automatic clean_reset();
      rst = 1'b0;
      sw  = '0;
      tick(2);
      rst = 1'b1;
      tick(2);
   endtask

   int c, hi, first;

   initial begin
      // 1. In reset with chattering inputs, all outputs stay 0.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("reset_outputs", {one_shot, level, busy}, '0);
         sw = (i % 2 == 0) ? 4'hF : 4'h0;
      end
      @(negedge clk);
      sw  = 4'hF;
      rst = 1'b1;
      c   = cyc;
      expect_pulse(1'b0, 4'b0001, c + 12);
      expect_pulse(1'b0, 4'b0010, c + 22);
      expect_pulse(1'b0, 4'b0100, c + 32);
      expect_pulse(1'b0, 4'b1000, c + 42);
      tick(50);
      check("level_all_pressed", level, 4'hF);
      check("busy_idle_after_all", busy, 1'b0);
      clean_reset();

      // 2. Single press on ch1.
      sw = 4'b0010;
      c  = cyc;
      expect_pulse(1'b0, 4'b0010, c + 12);
      watch_busy(20, -1, '0, hi, first);
      check("t2_busy_cycles", hi, 9);
      check("t2_busy_first", first, c + 3);
      check("t2_level", level, 4'b0010);

      // 3. 3-cycle glitch on ch2: timer used, no pulse, level unchanged.
      sw = 4'b0110;
      c  = cyc;
      watch_busy(20, 2, 4'b0010, hi, first);
      check("t3_busy_cycles", hi, 9);
      check("t3_busy_first", first, c + 3);
      check("t3_level", level, 4'b0010);

      // 4. rr_ptr is 3: ch3 and ch0 rise together, ch3 is served first.
      sw = 4'b1011;
      c  = cyc;
      expect_pulse(1'b0, 4'b1000, c + 12);
      expect_pulse(1'b0, 4'b0001, c + 22);
      tick(30);
      check("t4_level", level, 4'b1011);

      // 5. Reset in the middle of the window, then a fresh full sequence.
      clean_reset();
      sw = 4'b0010;
      c  = cyc;
      tick(7);
      check("t5_busy_before_rst", busy, 1'b1);
      rst = 1'b0;
      #1;
      check("t5_async_clear", {one_shot, level, busy}, '0);
      tick(2);
      check("t5_held_clear", {one_shot, level, busy}, '0);
      rst = 1'b1;
      c   = cyc;
      expect_pulse(1'b0, 4'b0010, c + 12);
      tick(20);
      check("t5_level", level, 4'b0010);

      // 6. Release of ch1: level clears, no press pulse.
      sw = 4'b0000;
      c  = cyc;
`ifdef RELEASE_PULSE_EN
      expect_pulse(1'b1, 4'b0010, c + 12);
`endif
      tick(20);
      check("t6_level", level, 4'b0000);
      check("t6_busy", busy, 1'b0);

      tick(5);
      while (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         n_cmp++;
         n_fail++;
         $display("FAIL missing_pulse: rel=%0d %b expected at cycle %0d, never seen", e.rel, e.val, e.cyc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
